// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding req/ack read at a time into a DEPTH-entry prefetch FIFO; head is combinational.
// The fetcher stalls while the FIFO is full; Redirect flushes the FIFO and discards any in-flight word.
module ifu_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h00000C00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Redirect,
  input  logic [29:0] RedirectPC,
  output logic        MemReq,
  output logic [29:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [29:0] InstrPC,
  input  logic        InstrReady
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [29:0]   fetch_pc;
  logic [29:0]   req_addr;
  logic [31:0]   buf_instr [DEPTH];
  logic [29:0]   buf_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic outstanding;
  logic can_issue;
  logic push;
  logic pop;

  assign outstanding = (state == S_REQ) || (state == S_DROP);
  assign can_issue   = (state == S_IDLE) && !Redirect && (count < CNT_FULL);
  assign push        = (state == S_REQ) && MemAck && !Redirect;
  assign pop         = InstrValid && InstrReady && !Redirect;

  // Reset gates the idle-issue path so MemReq drops the instant Reset rises.
  assign MemReq  = (can_issue && !Reset) || outstanding;
  assign MemAddr = outstanding ? req_addr : fetch_pc;

  assign InstrValid = (count != '0);
  assign Instr      = InstrValid ? buf_instr[rd_ptr] : 32'h0;
  assign InstrPC    = InstrValid ? buf_pc[rd_ptr]    : 30'h0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_issue) begin
            req_addr <= fetch_pc;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (MemAck)        state <= S_IDLE;
          else if (Redirect) state <= S_DROP;
        end
        S_DROP: begin
          if (MemAck) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (Redirect)  fetch_pc <= RedirectPC;
      else if (push) fetch_pc <= fetch_pc + 30'd1;

      if (Redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + (AW + 1)'(1);
        else if (pop && !push) count <= count - (AW + 1)'(1);
      end
    end
  end

  // Storage needs no reset: the head mux forces zeros while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= MemRdata;
      buf_pc[wr_ptr]    <= req_addr;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a granted-ack memory model, directed stimulus, and a scoreboard
// monitor that pops expected {instr, pc} pairs whenever decode accepts a head word.
module tb_ifu_fetch;

  logic        Clk        = 1'b0;
  logic        Reset      = 1'b1;
  logic        Redirect   = 1'b0;
  logic [29:0] RedirectPC = 30'h0;
  logic        MemReq;
  logic [29:0] MemAddr;
  logic        MemAck     = 1'b0;
  logic [31:0] MemRdata   = 32'h0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [29:0] InstrPC;
  logic        InstrReady = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Stimulus grants acks (granted/force_cnt); the memory model consumes them (used/force_used).
  int granted    = 0;
  int used       = 0;
  int force_cnt  = 0;
  int force_used = 0;
  int ack_delay  = 1;
  int wait_cnt   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  ifu_fetch #(.DEPTH(4), .RESET_PC(30'h00000C00)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemRdata   (MemRdata),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrReady (InstrReady)
  );

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'h00000C00: return 32'h24080001;
      30'h00000C01: return 32'h24090002;
      30'h00000C02: return 32'h010A5020;
      default:      return {~a[15:0], a[15:0]};
    endcase
  endfunction

  // Acks a request once it has been seen for more than ack_delay cycles, if an ack is granted.
  always @(negedge Clk) begin
    if (MemAck) MemAck = 1'b0;
    if (force_cnt != force_used) begin
      MemAck     = 1'b1;
      MemRdata   = 32'hDEADBEEF;
      force_used = force_used + 1;
      wait_cnt   = 0;
    end else if (!MemReq || granted == used) begin
      wait_cnt = 0;
    end else begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt > ack_delay) begin
        MemAck   = 1'b1;
        MemRdata = mem_word(MemAddr);
        used     = used + 1;
        wait_cnt = 0;
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk30(input string name, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] instr, input logic [29:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
    #1;
  endtask

  task automatic drain(input string name, input int n);
    int k = 0;
    while (sb.size() != 0 && k < n) begin
      smp();
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d words still pending, required 0", name, sb.size());
    end
  endtask

  task automatic wait_acks(input string name, input int n);
    int k = 0;
    while (used != granted && k < n) begin
      smp();
      k++;
    end
    checks++;
    if (used != granted) begin
      failures++;
      $display("FAIL %s: %0d acks delivered, required %0d", name, used, granted);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && InstrValid && InstrReady && !Redirect) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got pc %h instr %h, required no output", InstrPC, Instr);
        end else begin
          e = sb.pop_front();
          chk30("sb_pc", InstrPC, e.pc);
          chk32("sb_instr", Instr, e.instr);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state, memory idle.
    smp();
    chk1 ("rst_memreq",   MemReq,     1'b0);
    chk1 ("rst_valid",    InstrValid, 1'b0);
    chk30("rst_memaddr",  MemAddr,    30'h00000C00);
    chk32("rst_instr",    Instr,      32'h0);
    chk30("rst_instrpc",  InstrPC,    30'h0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    smp();
    chk1 ("first_req",    MemReq,     1'b1);
    chk30("first_addr",   MemAddr,    30'h00000C00);

    // Three words acked one cycle after each request, consumed in order.
    nxt();
    InstrReady = 1'b1;
    granted += 3;
    expect_word(32'h24080001, 30'h00000C00);
    expect_word(32'h24090002, 30'h00000C01);
    expect_word(32'h010A5020, 30'h00000C02);
    smp();
    chk1 ("req_hold",     MemReq,     1'b1);
    chk30("req_hold_addr", MemAddr,   30'h00000C00);
    drain("stream_drain", 60);

    // Fill the FIFO with decode stalled, then release it.
    nxt();
    InstrReady = 1'b0;
    granted += 4;
    expect_word(32'hF3FC0C03, 30'h00000C03);
    expect_word(32'hF3FB0C04, 30'h00000C04);
    expect_word(32'hF3FA0C05, 30'h00000C05);
    expect_word(32'hF3F90C06, 30'h00000C06);
    wait_acks("fill_acks", 60);
    smp();
    chk1 ("full_noreq",   MemReq,     1'b0);
    chk1 ("full_valid",   InstrValid, 1'b1);
    chk30("full_headpc",  InstrPC,    30'h00000C03);
    chk32("full_head",    Instr,      32'hF3FC0C03);
    smp();
    chk1 ("full_noreq2",  MemReq,     1'b0);
    nxt();
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk1("pop_burst_valid", InstrValid, 1'b1);
    end
    smp();
    chk1 ("burst_empty",  InstrValid, 1'b0);
    chk1 ("refill_req",   MemReq,     1'b1);
    chk30("refill_addr",  MemAddr,    30'h00000C07);

    // Redirect while a request waits: old address held, word discarded.
    nxt();
    ack_delay = 3;
    granted += 1;
    nxt();
    Redirect   = 1'b1;
    RedirectPC = 30'h00000D00;
    smp();
    chk30("drop_addr0",   MemAddr,    30'h00000C07);
    nxt();
    Redirect = 1'b0;
    smp();
    chk1 ("drop_req1",    MemReq,     1'b1);
    chk30("drop_addr1",   MemAddr,    30'h00000C07);
    nxt();
    smp();
    chk30("drop_addr2",   MemAddr,    30'h00000C07);
    nxt();
    smp();
    chk1 ("redir_req",    MemReq,     1'b1);
    chk30("redir_addr",   MemAddr,    30'h00000D00);
    chk1 ("redir_empty",  InstrValid, 1'b0);

    // Redirect coinciding with an ack and a pop while two words are buffered.
    nxt();
    InstrReady = 1'b0;
    ack_delay  = 1;
    granted += 2;
    wait_acks("pair_acks", 40);
    smp();
    chk1 ("pair_req",     MemReq,     1'b1);
    chk30("pair_addr",    MemAddr,    30'h00000D02);
    chk1 ("pair_valid",   InstrValid, 1'b1);
    chk30("pair_headpc",  InstrPC,    30'h00000D00);
    nxt();
    granted += 1;
    ack_delay  = 0;
    Redirect   = 1'b1;
    RedirectPC = 30'h00000E00;
    InstrReady = 1'b1;
    smp();
    chk30("preflush_headpc", InstrPC, 30'h00000D00);
    nxt();
    Redirect  = 1'b0;
    ack_delay = 1;
    smp();
    chk1 ("flush_valid",  InstrValid, 1'b0);
    chk30("flush_addr",   MemAddr,    30'h00000E00);
    chk1 ("flush_req",    MemReq,     1'b1);
    nxt();
    smp();
    chk30("flush_addr2",  MemAddr,    30'h00000E00);
    chk1 ("flush_valid2", InstrValid, 1'b0);

    // Redirect to the top word address; fetch pointer wraps to zero.
    nxt();
    Redirect   = 1'b1;
    RedirectPC = 30'h3FFFFFFF;
    smp();
    nxt();
    Redirect = 1'b0;
    granted += 1;
    smp();
    chk30("drop2_hold",   MemAddr,    30'h00000E00);
    nxt();
    smp();
    nxt();
    granted += 1;
    smp();
    chk1 ("top_req",      MemReq,     1'b1);
    chk30("top_addr",     MemAddr,    30'h3FFFFFFF);
    chk1 ("top_empty",    InstrValid, 1'b0);
    nxt();
    InstrReady = 1'b0;
    smp();
    nxt();
    smp();
    chk1 ("top_valid",    InstrValid, 1'b1);
    chk30("top_headpc",   InstrPC,    30'h3FFFFFFF);
    chk32("top_head",     Instr,      32'h0000FFFF);
    chk1 ("wrap_req",     MemReq,     1'b1);
    chk30("wrap_addr",    MemAddr,    30'h00000000);

    // Reset in the middle of a request; a late ack after release is ignored.
    nxt();
    smp();
    #1 Reset = 1'b1;
    #1;
    chk1 ("midrst_req",   MemReq,     1'b0);
    chk1 ("midrst_valid", InstrValid, 1'b0);
    chk32("midrst_instr", Instr,      32'h0);
    chk30("midrst_addr",  MemAddr,    30'h00000C00);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    force_cnt += 1;
    smp();
    chk1 ("postrst_req",  MemReq,     1'b1);
    chk30("postrst_addr", MemAddr,    30'h00000C00);
    nxt();
    InstrReady = 1'b1;
    granted += 1;
    expect_word(32'h24080001, 30'h00000C00);
    smp();
    chk1 ("late_ack_ignored", InstrValid, 1'b0);
    chk1 ("late_ack_req",     MemReq,     1'b1);
    chk30("late_ack_addr",    MemAddr,    30'h00000C00);
    drain("final_drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
